// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment scan multiplexer.
package seg7_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} patterns for nibbles 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;
endpackage

// File: rtl/hex_seg7_dec.sv
// Combinational nibble to active-low seven-segment decode.
module hex_seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 4-digit display driver with dark gaps between digits.
// Optional leading-zero suppression: define SEG7_LZ_BLANK_EN.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  digit_en,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);
  localparam logic [15:0] DRV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLK_LAST = 16'(BLANK_CYC - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] shadow;
  logic [3:0]  cur_nib;
  logic [6:0]  dec_seg;
  logic        drive_entry, frame_end, show;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)  shadow <= '0;
    else if (load) shadow <= value;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 16'd1;
    idx_nxt     = idx;
    drive_entry = 1'b0;
    frame_end   = 1'b0;
    case (state)
      BLANK: if (cnt == BLK_LAST) begin
        state_nxt   = DRIVE;
        cnt_nxt     = '0;
        drive_entry = 1'b1;
      end
      DRIVE: if (cnt == DRV_LAST) begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
        idx_nxt   = idx + 2'd1;
        frame_end = (idx == 2'd3);
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The digit nibble is frozen at DRIVE entry so mid-digit loads don't tear.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= BLANK;
      cnt     <= '0;
      idx     <= '0;
      cur_nib <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      if (drive_entry) cur_nib <= shadow[{idx, 2'b00} +: 4];
    end

`ifdef SEG7_LZ_BLANK_EN
  logic sup, sup_nxt;

  // Digit k>0 goes dark when it and every higher nibble are zero.
  always_comb begin
    sup_nxt = 1'b0;
    case (idx)
      2'd1:    sup_nxt = (shadow[15:4]  == 12'h000);
      2'd2:    sup_nxt = (shadow[15:8]  == 8'h00);
      2'd3:    sup_nxt = (shadow[15:12] == 4'h0);
      default: sup_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)         sup <= 1'b0;
    else if (drive_entry) sup <= sup_nxt;

  assign show = (state == DRIVE) && digit_en[idx] && !sup;
`else
  assign show = (state == DRIVE) && digit_en[idx];
`endif

  hex_seg7_dec u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      an         <= 4'b1111;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      an         <= show ? ~(4'b0001 << idx) : 4'b1111;
      seg        <= show ? dec_seg : SEG_BLANK;
      frame_done <= frame_end;
    end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized + directed bench for seg7_scan_mux against a time-arithmetic display model.
module tb_seg7_scan_mux;
  localparam int S  = 4;
  localparam int B  = 1;
  localparam int SL = S + B;

  localparam logic [6:0] PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int vectors = 0, errors = 0;
  int t = 0, fd_cnt = 0;
  logic [15:0] m_shadow = '0;
  logic [3:0]  m_nib = '0;
  bit          m_sup = 1'b0;

  seg7_scan_mux #(.SCAN_DIV(S), .BLANK_CYC(B)) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .load(load),
    .digit_en(digit_en), .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic bit lz_dark(input logic [15:0] sh, input int d);
`ifdef SEG7_LZ_BLANK_EN
    return (d > 0) && ((sh >> (4 * d)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d got %b exp %b", tag, t, got, exp);
    end
  endtask

  task automatic chk7(input string tag, input logic [6:0] got, input logic [6:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d got %b exp %b", tag, t, got, exp);
    end
  endtask

  // One clock: the cycle numbered t (since reset release) ends; outputs then reflect it.
  task automatic tick();
    int q, d;
    bit lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_fd;
    q = t % SL;
    d = (t / SL) % 4;
    if (q == B - 1) begin
      m_nib = m_shadow[4*d +: 4];
      m_sup = lz_dark(m_shadow, d);
    end
    if (load) m_shadow = value;
    lit   = (q >= B) && digit_en[d] && !m_sup;
    e_an  = lit ? ~(4'b0001 << d) : 4'b1111;
    e_seg = lit ? PAT[m_nib] : 7'b1111111;
    e_fd  = (d == 3) && (q == SL - 1);
    @(posedge clk); #1;
    t++;
    chk4("an", an, e_an);
    chk7("seg", seg, e_seg);
    chk4("frame_done", {3'b0, frame_done}, {3'b0, e_fd});
    if (frame_done) fd_cnt++;
  endtask

  task automatic check_dark(input string tag);
    chk4({tag, "_an"}, an, 4'b1111);
    chk7({tag, "_seg"}, seg, 7'b1111111);
    chk4({tag, "_fd"}, {3'b0, frame_done}, 4'b0000);
  endtask

  task automatic release_reset();
    reset_n  = 1'b1;
    t        = 0;
    m_shadow = '0;
    m_nib    = '0;
    m_sup    = 1'b0;
  endtask

  // Advance until the current cycle is DRIVE of digit dg with at least one lit output cycle.
  task automatic run_to_drive(input int dg);
    int n;
    n = 0;
    while (!((t % SL) >= B + 1 && ((t / SL) % 4) == dg) && n < 100) begin
      tick();
      n++;
    end
    vectors++;
    assert (n < 100) else begin
      errors++;
      $error("FAIL run_to_drive got timeout exp digit %0d", dg);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) begin
      @(posedge clk); #1;
      check_dark("reset");
    end

    // 12AF: first frame digit 0 still shows the reset shadow, later frames show F,A,2,1
    release_reset();
    value = 16'h12AF; load = 1'b1;
    tick();
    load = 1'b0;
    fd_cnt = 0;
    repeat (59) tick();
    chk4("fd_pulses_12AF", 4'(fd_cnt), 4'd3);

    // Load 0000 mid-DRIVE of digit 1
    run_to_drive(1);
    value = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (25) tick();

    // Back-to-back loads, last wins
    value = 16'h1111; load = 1'b1;
    tick();
    value = 16'h2222;
    tick();
    load = 1'b0;
    repeat (25) tick();

    // Digit enables 0101, timing unaffected
    digit_en = 4'b0101;
    value = 16'h9C3E; load = 1'b1;
    tick();
    load = 1'b0;
    fd_cnt = 0;
    repeat (40) tick();
    chk4("fd_pulses_en0101", 4'(fd_cnt), 4'd2);
    digit_en = 4'hF;

    // Leading-zero pattern
    value = 16'h0030; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (45) tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      value = 16'($urandom);
      load  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) digit_en = 4'($urandom);
      tick();
    end
    load = 1'b0;
    digit_en = 4'hF;
    value = 16'h5678; load = 1'b1;
    tick();
    load = 1'b0;

    // Asynchronous reset during DRIVE of digit 2
    run_to_drive(2);
    chk4("pre_reset_an", an, 4'b1011);
    reset_n = 1'b0;
    #1;
    check_dark("async");
    repeat (2) begin
      @(posedge clk); #1;
      check_dark("held");
    end
    release_reset();
    repeat (B + 1) tick();
    chk4("first_digit_an", an, 4'b1110);
    chk7("first_digit_seg", seg, 7'b1000000);
    repeat (25) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
